// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : wb_cmd_master
//  Description : Single-beat Wishbone classic initiator. Commands arrive on a
//                valid/ready port and become one read or write cycle. The read
//                data, or an error flag on abort, is returned on a
//                valid/ready response port.
//                Optional build macro WBM_TIMEOUT_EN aborts a cycle that is
//                not acknowledged within TIMEOUT bus cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    // command port
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    // response port
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    // Wishbone master port
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    localparam int c_SW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state,     w_state_nxt;
    logic            r_cmd_ready, w_cmd_ready_nxt;
    logic            r_cyc,       w_cyc_nxt;
    logic            r_we,        w_we_nxt;
    logic [c_SW-1:0] r_sel,       w_sel_nxt;
    logic [AW-1:0]   r_adr,       w_adr_nxt;
    logic [DW-1:0]   r_dat_o,     w_dat_o_nxt;
    logic            r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0]   r_rsp_dat,   w_rsp_dat_nxt;
    logic            r_rsp_err,   w_rsp_err_nxt;

`ifdef WBM_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT + 1);

    logic [c_CW-1:0] r_to_cnt, w_to_cnt_nxt;
    logic            w_to_hit;

    // Last waiting cycle: the abort happens on this edge unless ack arrives.
    assign w_to_hit = (r_to_cnt == c_CW'(TIMEOUT - 1));
`endif

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        w_state_nxt     = r_state;
        w_cyc_nxt       = r_cyc;
        w_we_nxt        = r_we;
        w_sel_nxt       = r_sel;
        w_adr_nxt       = r_adr;
        w_dat_o_nxt     = r_dat_o;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;
`ifdef WBM_TIMEOUT_EN
        w_to_cnt_nxt    = r_to_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_we_nxt    = cmd_we;
                    w_sel_nxt   = cmd_sel;
                    w_adr_nxt   = cmd_adr;
                    w_dat_o_nxt = cmd_dat;
                    w_cyc_nxt   = 1'b1;
                    w_state_nxt = S_BUS;
`ifdef WBM_TIMEOUT_EN
                    w_to_cnt_nxt = '0;
`endif
                end
            end
            S_BUS: begin
                // Ack is checked first so that it wins over a same-cycle timeout.
                if (wbm_ack_i) begin
                    w_rsp_dat_nxt   = r_we ? '0 : wbm_dat_i;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_cyc_nxt       = 1'b0;
                    w_state_nxt     = S_RESP;
                end
`ifdef WBM_TIMEOUT_EN
                else if (w_to_hit) begin
                    w_rsp_dat_nxt   = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_cyc_nxt       = 1'b0;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_cyc_nxt       = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
        endcase
        // cmd_ready is registered from the decoded next state to stay glitch-free.
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // State and output registers; reset asserts asynchronously, so cyc/stb
    // drop immediately and any in-flight command is abandoned.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat_o     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_cyc       <= w_cyc_nxt;
            r_we        <= w_we_nxt;
            r_sel       <= w_sel_nxt;
            r_adr       <= w_adr_nxt;
            r_dat_o     <= w_dat_o_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
`ifdef WBM_TIMEOUT_EN
            r_to_cnt    <= w_to_cnt_nxt;
`endif
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat_o;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_cmd_master
//  Description : Self-checking bench for wb_cmd_master: directed table,
//                random transactions against a transaction-level model, and
//                hand-written reset / back-to-back sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef WBM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [3:0]    cmd_sel = '0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic          wbm_ack_i;
    logic [DW-1:0] wbm_dat_i = '0;

    int n_vec = 0;
    int n_bad = 0;

    // slave model: ack after ack_dly cycles of cyc (negative = never)
    int   ack_dly   = -1;
    int   cyc_cnt   = 0;
    logic stray_ack = 1'b0;

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_sel    (cmd_sel),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dat    (rsp_dat),
        .rsp_err    (rsp_err),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_dat_i  (wbm_dat_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= wbm_cyc_o ? cyc_cnt + 1 : 0;

    assign wbm_ack_i = stray_ack | (wbm_cyc_o && (ack_dly >= 0) && (cyc_cnt == ack_dly));

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] sdat;
        int          dly;
        int          hold;
        int          exp_len;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Transaction-level expectation: did the slave answer before the deadline?
    function automatic vec_t expect_of(input vec_t v);
        vec_t r = v;
        bit acked = (v.dly >= 0) && (!TO_EN || v.dly < TO);
        r.exp_len = acked ? v.dly + 1 : TO;
        r.exp_err = !acked;
        r.exp_dat = (acked && !v.we) ? v.sdat : 32'h0;
        return r;
    endfunction

    // One full command/cycle/response transaction, starting from IDLE at posedge+1.
    task automatic run_txn(input vec_t v);
        int n = 0;
        bit bus_bad = 0;
        bit bp_bad = 0;
        ack_dly   = v.dly;
        wbm_dat_i = v.sdat;
        cmd_we    = v.we;
        cmd_sel   = v.sel;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_we    = ~v.we;
        cmd_sel   = ~v.sel;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        while (wbm_cyc_o && n < 300) begin
            if (wbm_stb_o !== 1'b1 || wbm_we_o !== v.we || wbm_sel_o !== v.sel ||
                wbm_adr_o !== v.adr || wbm_dat_o !== v.dat || cmd_ready !== 1'b0)
                bus_bad = 1;
            n++;
            @(posedge clk); #1;
        end
        chk("cyc_len", n, v.exp_len);
        chk("bus_fields_stable", bus_bad, 0);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_dat", rsp_dat, v.exp_dat);
        chk("rsp_err", rsp_err, v.exp_err);
        for (int i = 0; i < v.hold; i++) begin
            cmd_valid = 1'b1;
            stray_ack = 1'b1;
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_dat !== v.exp_dat || rsp_err !== v.exp_err ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
                bp_bad = 1;
        end
        if (v.hold > 0) chk("backpressure_stable", bp_bad, 0);
        cmd_valid = 1'b0;
        stray_ack = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
        chk("cyc_idle", wbm_cyc_o, 0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        int rises, last, bad_gap, glitch, high;
        logic prev;

        // directed table: {we, sel, adr, dat, sdat, dly, hold, exp_len, exp_dat, exp_err}
        tbl.push_back('{1'b0, 4'hF, 32'h3000_0000, 32'h0, 32'h0000_0008, 2, 10, 3, 32'h0000_0008, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 32'h3000_0004, 32'h0003_0005, 32'hDEAD_BEEF, 1, 0, 2, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 4'h3, 32'h3000_0010, 32'h0, 32'h1234_5678, 0, 2, 1, 32'h1234_5678, 1'b0});
        tbl.push_back('{1'b1, 4'h1, 32'h3000_0020, 32'hA5A5_5A5A, 32'h0, 3, 1, 4, 32'h0, 1'b0});
`ifdef WBM_TIMEOUT_EN
        tbl.push_back('{1'b0, 4'hF, 32'h3000_0030, 32'h0, 32'hCAFE_F00D, -1, 1, 4, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 32'h3000_0034, 32'h0, 32'h0BAD_F00D, 3, 1, 4, 32'h0BAD_F00D, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 32'h3000_0038, 32'h1111_2222, 32'h0, 4, 0, 4, 32'h0, 1'b1});
`endif

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1);

        foreach (tbl[i]) run_txn(tbl[i]);

        // randomized transactions against the model
        for (int k = 0; k < 24; k++) begin
            v.we   = 1'($urandom_range(0, 1));
            v.sel  = 4'($urandom);
            v.adr  = $urandom;
            v.dat  = $urandom;
            v.sdat = $urandom;
            v.dly  = TO_EN ? int'($urandom_range(0, 5)) - 1 : int'($urandom_range(0, 4));
            v.hold = int'($urandom_range(0, 3));
            v = expect_of(v);
            run_txn(v);
        end

        // reset in the middle of a bus cycle drops cyc/stb without a clock edge
        ack_dly   = -1;
        cmd_we    = 1'b0;
        cmd_sel   = 4'hF;
        cmd_adr   = 32'h3000_0040;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("midbus_cyc_before", wbm_cyc_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midbus_rst_cyc", wbm_cyc_o, 0);
        chk("midbus_rst_stb", wbm_stb_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);

        // back-to-back with a 1-cycle-ack slave: one cycle every 4 clocks
        ack_dly   = 1;
        rsp_ready = 1'b1;
        cmd_we    = 1'b1;
        cmd_dat   = 32'h0000_0077;
        cmd_valid = 1'b1;
        rises = 0; last = -100; bad_gap = 0; glitch = 0; high = 0; prev = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (wbm_stb_o !== wbm_cyc_o) glitch++;
            if (wbm_cyc_o === 1'b1) high++;
            if (wbm_cyc_o === 1'b1 && prev === 1'b0) begin
                if (rises > 0 && (i - last) != 4) bad_gap++;
                last = i;
                rises++;
            end
            prev = wbm_cyc_o;
        end
        cmd_valid = 1'b0;
        chk("b2b_cycles", rises, 10);
        chk("b2b_spacing", bad_gap, 0);
        chk("b2b_cyc_high", high, 20);
        chk("b2b_stb_eq_cyc", glitch, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // hard stop in case the DUT wedges somewhere the bounded loops do not cover
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
